// File: rtl/audio_sched_pkg.sv
// Shared types and constants for the audio output scheduler.
package audio_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    RUN
  } sched_state_t;

  typedef struct packed {
    logic [15:0] left;
    logic [15:0] right;
  } sample_t;

  localparam sample_t SILENCE = '0;

endpackage

// File: rtl/sample_fifo.sv
// Sample FIFO: synchronous push/pop, flush clears occupancy, head is combinational.
module sample_fifo
  import audio_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                   Clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic [31:0]            push_data,
  input  logic                   pop,
  output logic [31:0]            head,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  sample_t       mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !flush && (level != LW'(DEPTH));
  assign do_pop  = pop && !flush && (level != '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge Clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/audio_out_scheduler.sv
// Round-robin two-source sample scheduler feeding the I2S serializer via a FIFO.
// Optional AUDIO_SCHED_UNDERRUN_CNT_EN adds a saturating underrun counter port.
module audio_out_scheduler
  import audio_sched_pkg::*;
#(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned PRIME_LVL = 4
) (
  input  logic                   Clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [31:0]            src0_data,
  input  logic                   src0_valid,
  output logic                   src0_ready,
  input  logic [31:0]            src1_data,
  input  logic                   src1_valid,
  output logic                   src1_ready,
  input  logic                   Send_Done,
  output logic [31:0]            data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   underrun,
  output logic                   busy
`ifdef AUDIO_SCHED_UNDERRUN_CNT_EN
  ,
  output logic [15:0]            underrun_cnt
`endif
);

  localparam int unsigned LW = $clog2(DEPTH) + 1;

  sched_state_t state;
  logic         sd_meta;
  logic         sd_sync;
  logic         sd_prev;
  logic         frame_req;
  logic         prefer1;
  logic         grant1;
  logic         active;
  logic         full;
  logic         empty;
  logic         acc0;
  logic         acc1;
  logic         push;
  logic         pop;
  logic         flush;
  logic [31:0]  push_data;
  sample_t      head;

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      sd_meta <= 1'b0;
      sd_sync <= 1'b0;
      sd_prev <= 1'b0;
    end else begin
      sd_meta <= Send_Done;
      sd_sync <= sd_meta;
      sd_prev <= sd_sync;
    end
  end

  assign frame_req = sd_sync && !sd_prev;

  // Readies come from the registered level, so a same-cycle pop never frees a slot.
  assign active     = (state != IDLE);
  assign full       = (level == LW'(DEPTH));
  assign empty      = (level == '0);
  assign grant1     = src1_valid && (!src0_valid || prefer1);
  assign src0_ready = active && !grant1 && !full;
  assign src1_ready = active && grant1 && !full;
  assign acc0       = src0_valid && src0_ready;
  assign acc1       = src1_valid && src1_ready;
  assign push       = (acc0 || acc1) && enable;
  assign push_data  = acc1 ? src1_data : src0_data;
  assign pop        = frame_req && (state == RUN) && !empty;
  assign flush      = !enable || (state == IDLE);

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset)    prefer1 <= 1'b0;
    else if (push) prefer1 <= acc0;
  end

  sample_fifo #(.DEPTH(DEPTH)) u_fifo (
    .Clk       (Clk),
    .reset     (reset),
    .flush     (flush),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .level     (level)
  );

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      data     <= SILENCE;
      underrun <= 1'b0;
      busy     <= 1'b0;
`ifdef AUDIO_SCHED_UNDERRUN_CNT_EN
      underrun_cnt <= '0;
`endif
    end else begin
      underrun <= 1'b0;
      if (!enable) begin
        state <= IDLE;
        busy  <= 1'b0;
        data  <= SILENCE;
`ifdef AUDIO_SCHED_UNDERRUN_CNT_EN
        underrun_cnt <= '0;
`endif
      end else begin
        case (state)
          IDLE: begin
            state <= PRIME;
            busy  <= 1'b1;
          end
          PRIME: begin
            if (frame_req) data <= SILENCE;
            if (level >= LW'(PRIME_LVL)) state <= RUN;
          end
          RUN: begin
            if (frame_req) begin
              if (empty) begin
                data     <= SILENCE;
                underrun <= 1'b1;
                state    <= PRIME;
`ifdef AUDIO_SCHED_UNDERRUN_CNT_EN
                if (underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
`endif
              end else begin
                data <= head;
              end
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_audio_out_scheduler.sv
// Randomized and directed bench for audio_out_scheduler against a queue-based reference model.
module tb_audio_out_scheduler;

  localparam int DEPTH     = 8;
  localparam int PRIME_LVL = 4;
  localparam int LW        = $clog2(DEPTH) + 1;

  logic          Clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [31:0]   src0_data;
  logic          src0_valid;
  logic          src0_ready;
  logic [31:0]   src1_data;
  logic          src1_valid;
  logic          src1_ready;
  logic          Send_Done;
  logic [31:0]   data;
  logic [LW-1:0] level;
  logic          underrun;
  logic          busy;
`ifdef AUDIO_SCHED_UNDERRUN_CNT_EN
  logic [15:0]   underrun_cnt;
`endif

  always #5 Clk = ~Clk;

  audio_out_scheduler #(.DEPTH(DEPTH), .PRIME_LVL(PRIME_LVL)) dut (
    .Clk        (Clk),
    .reset      (reset),
    .enable     (enable),
    .src0_data  (src0_data),
    .src0_valid (src0_valid),
    .src0_ready (src0_ready),
    .src1_data  (src1_data),
    .src1_valid (src1_valid),
    .src1_ready (src1_ready),
    .Send_Done  (Send_Done),
    .data       (data),
    .level      (level),
    .underrun   (underrun),
    .busy       (busy)
`ifdef AUDIO_SCHED_UNDERRUN_CNT_EN
    ,
    .underrun_cnt (underrun_cnt)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: phase 0 = idle, 1 = priming, 2 = running.
  int          phase;
  logic [31:0] q[$];
  logic [31:0] m_data;
  bit          m_under;
  int          m_last;
  int          m_ucnt;
  bit          s1, s2, s3;
  int          m_win;
  bit          er0, er1;

  function automatic logic [31:0] rnd();
    return $urandom | 32'h1;
  endfunction

  function automatic void model_reset();
    phase  = 0;
    q.delete();
    m_data = '0;
    m_under = 0;
    m_last = 1;
    m_ucnt = 0;
    s1 = 0; s2 = 0; s3 = 0;
  endfunction

  function automatic void model_comb();
    m_win = -1;
    if (src0_valid && src1_valid) m_win = (m_last == 0) ? 1 : 0;
    else if (src0_valid)          m_win = 0;
    else if (src1_valid)          m_win = 1;
    er0 = (phase != 0) && (q.size() < DEPTH) && (m_win == 0);
    er1 = (phase != 0) && (q.size() < DEPTH) && (m_win == 1);
  endfunction

  function automatic void model_update();
    int acc;
    int old_size;
    bit fr;
    if (!reset) begin
      model_reset();
      return;
    end
    fr = s2 && !s3;
    s3 = s2; s2 = s1; s1 = Send_Done;
    m_under = 0;
    if (!enable) begin
      phase = 0;
      q.delete();
      m_data = '0;
      m_ucnt = 0;
      return;
    end
    acc = -1;
    if (src0_valid && er0) acc = 0;
    if (src1_valid && er1) acc = 1;
    old_size = q.size();
    case (phase)
      0: phase = 1;
      1: begin
        if (fr) m_data = '0;
        if (old_size >= PRIME_LVL) phase = 2;
      end
      default: begin
        if (fr) begin
          if (old_size > 0) m_data = q.pop_front();
          else begin
            m_data = '0;
            m_under = 1;
            phase = 1;
            if (m_ucnt < 65535) m_ucnt++;
          end
        end
      end
    endcase
    if (acc == 0) begin q.push_back(src0_data); m_last = 0; end
    if (acc == 1) begin q.push_back(src1_data); m_last = 1; end
  endfunction

  task automatic drive(input bit v0, input logic [31:0] d0, input bit v1, input logic [31:0] d1);
    src0_valid = v0; src0_data = d0;
    src1_valid = v1; src1_data = d1;
  endtask

  task automatic clk_cycle();
    model_comb();
    @(posedge Clk);
    model_update();
    @(negedge Clk);
  endtask

  // One Send_Done pulse (3 cycles high, 4 low); records observations for the caller.
  task automatic sd_frame(output int lat, output int under_seen, output int bad);
    logic [31:0]   prev;
    logic [LW-1:0] el;
    prev = data; lat = 0; under_seen = 0; bad = 0;
    for (int c = 1; c <= 7; c++) begin
      Send_Done = (c <= 3);
      clk_cycle();
      el = LW'(q.size());
      if (lat == 0 && data !== prev) lat = c;
      if (underrun === 1'b1) under_seen++;
      if (data !== m_data || level !== el || underrun !== m_under || busy !== (phase != 0)) bad++;
    end
    Send_Done = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b0; Send_Done = 1'b0;
    drive(1, 32'h1234_5678, 1, 32'h9ABC_DEF0);
    model_reset();
    repeat (3) clk_cycle();
    #1;
    n_cmp++; if (data !== 32'h0)   begin n_err++; $display("FAIL reset_data: got %h want 0", data); end
    n_cmp++; if (level !== '0)     begin n_err++; $display("FAIL reset_level: got %0d want 0", level); end
    n_cmp++; if (underrun !== 1'b0) begin n_err++; $display("FAIL reset_underrun: got %b want 0", underrun); end
    n_cmp++; if (busy !== 1'b0)    begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (src0_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready0: got %b want 0", src0_ready); end
    n_cmp++; if (src1_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready1: got %b want 0", src1_ready); end
    @(negedge Clk);
    reset = 1'b1;
    drive(0, '0, 0, '0);
    clk_cycle();
  endtask

  task automatic test_prime_serve();
    int lat, us, bad;
    logic [31:0] exp_s;
    enable = 1'b1;
    clk_cycle();
    for (int i = 1; i <= 4; i++) begin
      exp_s = {16'(i), 16'(i)};
      drive(1, exp_s, 0, '0);
      #1; model_comb();
      n_cmp++; if (src0_ready !== 1'b1) begin n_err++; $display("FAIL prime_ready0[%0d]: got %b want 1", i, src0_ready); end
      clk_cycle();
      n_cmp++; if (level !== LW'(i)) begin n_err++; $display("FAIL prime_level[%0d]: got %0d want %0d", i, level, i); end
    end
    drive(0, '0, 0, '0);
    clk_cycle();
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL prime_busy: got %b want 1", busy); end
    for (int k = 1; k <= 4; k++) begin
      exp_s = {16'(k), 16'(k)};
      sd_frame(lat, us, bad);
      n_cmp++; if (data !== exp_s) begin n_err++; $display("FAIL serve_data[%0d]: got %h want %h", k, data, exp_s); end
      n_cmp++; if (lat < 3 || lat > 4) begin n_err++; $display("FAIL serve_latency[%0d]: got %0d want 3..4", k, lat); end
      n_cmp++; if (bad != 0) begin n_err++; $display("FAIL serve_model[%0d]: got %0d bad cycles want 0", k, bad); end
    end
  endtask

  task automatic test_alternate();
    logic [31:0] served[$];
    int lat, us, bad, badsum;
    badsum = 0;
    for (int c = 0; c < 14; c++) begin
      drive(1, 32'hAAAA_0000 | 32'($urandom_range(1, 65535)), 1, 32'h5555_0000 | 32'($urandom_range(1, 65535)));
      #1; model_comb();
      n_cmp++; if (src0_ready !== er0) begin n_err++; $display("FAIL alt_ready0[%0d]: got %b want %b", c, src0_ready, er0); end
      n_cmp++; if (src1_ready !== er1) begin n_err++; $display("FAIL alt_ready1[%0d]: got %b want %b", c, src1_ready, er1); end
      clk_cycle();
    end
    n_cmp++; if (level !== LW'(8)) begin n_err++; $display("FAIL alt_full_level: got %0d want 8", level); end
    #1;
    n_cmp++; if (src0_ready !== 1'b0 || src1_ready !== 1'b0) begin
      n_err++; $display("FAIL alt_full_ready: got %b%b want 00", src0_ready, src1_ready);
    end
    clk_cycle();
    n_cmp++; if (level !== LW'(8)) begin n_err++; $display("FAIL alt_no_push_full: got %0d want 8", level); end
    drive(0, '0, 0, '0);
    for (int k = 0; k < 8; k++) begin
      sd_frame(lat, us, bad);
      served.push_back(data);
      badsum += bad;
    end
    n_cmp++; if (badsum != 0) begin n_err++; $display("FAIL alt_drain_model: got %0d bad cycles want 0", badsum); end
    for (int i = 1; i < 8; i++) begin
      n_cmp++; if (served[i][31:16] === served[i-1][31:16]) begin
        n_err++; $display("FAIL alt_order[%0d]: got %h after %h want other source", i, served[i], served[i-1]);
      end
    end
    n_cmp++; if (level !== '0) begin n_err++; $display("FAIL alt_drained: got %0d want 0", level); end
  endtask

  task automatic test_underrun();
    int lat, us, bad;
    logic [31:0] x;
    x = rnd();
    drive(1, x, 0, '0);
    clk_cycle();
    drive(0, '0, 0, '0);
    sd_frame(lat, us, bad);
    n_cmp++; if (data !== x) begin n_err++; $display("FAIL ur_last_sample: got %h want %h", data, x); end
    sd_frame(lat, us, bad);
    n_cmp++; if (data !== 32'h0) begin n_err++; $display("FAIL ur_data: got %h want 0", data); end
    n_cmp++; if (us != 1) begin n_err++; $display("FAIL ur_pulses: got %0d want 1", us); end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL ur_model: got %0d bad cycles want 0", bad); end
`ifdef AUDIO_SCHED_UNDERRUN_CNT_EN
    n_cmp++; if (underrun_cnt !== 16'd1) begin n_err++; $display("FAIL ur_cnt: got %0d want 1", underrun_cnt); end
`endif
    // Now priming: a frame must give silence without consuming the one queued sample.
    drive(1, rnd(), 0, '0);
    clk_cycle();
    drive(0, '0, 0, '0);
    sd_frame(lat, us, bad);
    n_cmp++; if (level !== LW'(1)) begin n_err++; $display("FAIL ur_prime_level: got %0d want 1", level); end
    n_cmp++; if (data !== 32'h0 || us != 0) begin n_err++; $display("FAIL ur_prime_silence: got %h/%0d want 0/0", data, us); end
  endtask

  task automatic test_simultaneous();
    int lat, us, bad;
    logic [31:0] old_head;
    for (int i = 0; i < 3; i++) begin
      drive(1, rnd(), 0, '0);
      clk_cycle();
    end
    drive(0, '0, 0, '0);
    clk_cycle();
    sd_frame(lat, us, bad);
    n_cmp++; if (level !== LW'(3)) begin n_err++; $display("FAIL sim_pre_level: got %0d want 3", level); end
    old_head = q[0];
    Send_Done = 1'b1;
    clk_cycle();
    clk_cycle();
    drive(1, rnd(), 0, '0);
    #1;
    n_cmp++; if (src0_ready !== 1'b1) begin n_err++; $display("FAIL sim_ready: got %b want 1", src0_ready); end
    clk_cycle();
    drive(0, '0, 0, '0);
    n_cmp++; if (level !== LW'(3)) begin n_err++; $display("FAIL sim_level: got %0d want 3", level); end
    n_cmp++; if (data !== old_head) begin n_err++; $display("FAIL sim_head: got %h want %h", data, old_head); end
    Send_Done = 1'b0;
    repeat (4) clk_cycle();
  endtask

  task automatic test_enable_off();
    int lat, us, bad;
    for (int i = 0; i < 2; i++) begin
      drive(1, rnd(), 0, '0);
      clk_cycle();
    end
    n_cmp++; if (level !== LW'(5)) begin n_err++; $display("FAIL off_pre_level: got %0d want 5", level); end
    enable = 1'b0;
    drive(1, rnd(), 0, '0);
    clk_cycle();
    drive(1, rnd(), 1, rnd());
    #1;
    n_cmp++; if (level !== '0) begin n_err++; $display("FAIL off_level: got %0d want 0", level); end
    n_cmp++; if (data !== 32'h0) begin n_err++; $display("FAIL off_data: got %h want 0", data); end
    n_cmp++; if (src0_ready !== 1'b0 || src1_ready !== 1'b0) begin
      n_err++; $display("FAIL off_ready: got %b%b want 00", src0_ready, src1_ready);
    end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL off_busy: got %b want 0", busy); end
    drive(0, '0, 0, '0);
    for (int k = 0; k < 2; k++) begin
      sd_frame(lat, us, bad);
      n_cmp++; if (data !== 32'h0 || bad != 0) begin
        n_err++; $display("FAIL off_frame[%0d]: got %h/%0d want 0/0", k, data, bad);
      end
    end
  endtask

  task automatic test_reset_midframe();
    int lat, us, bad;
    logic [LW-1:0] el;
    enable = 1'b1;
    clk_cycle();
    for (int i = 0; i < 4; i++) begin
      drive(1, rnd(), 0, '0);
      clk_cycle();
    end
    drive(0, '0, 0, '0);
    clk_cycle();
    sd_frame(lat, us, bad);
    n_cmp++; if (data === 32'h0) begin n_err++; $display("FAIL mr_pre_data: got %h want nonzero sample", data); end
    Send_Done = 1'b1;
    clk_cycle();
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    drive(1, rnd(), 1, rnd());
    #1;
    n_cmp++; if (data !== 32'h0) begin n_err++; $display("FAIL mr_data: got %h want 0", data); end
    n_cmp++; if (level !== '0) begin n_err++; $display("FAIL mr_level: got %0d want 0", level); end
    n_cmp++; if (busy !== 1'b0 || underrun !== 1'b0) begin n_err++; $display("FAIL mr_flags: got %b%b want 00", busy, underrun); end
    n_cmp++; if (src0_ready !== 1'b0 || src1_ready !== 1'b0) begin
      n_err++; $display("FAIL mr_ready: got %b%b want 00", src0_ready, src1_ready);
    end
    drive(0, '0, 0, '0);
    repeat (2) clk_cycle();
    reset = 1'b1;
    bad = 0;
    for (int c = 0; c < 8; c++) begin
      clk_cycle();
      el = LW'(q.size());
      if (data !== m_data || level !== el || underrun !== m_under || busy !== (phase != 0)) bad++;
    end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL mr_release_model: got %0d bad cycles want 0", bad); end
    n_cmp++; if (data !== 32'h0) begin n_err++; $display("FAIL mr_no_pop: got %h want 0", data); end
    Send_Done = 1'b0;
    repeat (4) clk_cycle();
  endtask

  task automatic test_random();
    int sd_hold = 0;
    int en_hold = 0;
    int pct;
    bit v0, v1;
    logic [LW-1:0] el;
    for (int c = 0; c < 600; c++) begin
      if (sd_hold == 0) begin
        Send_Done = ~Send_Done;
        sd_hold = Send_Done ? int'($urandom_range(2, 5)) : int'($urandom_range(3, 14));
      end
      sd_hold--;
      if (en_hold > 0) begin en_hold--; enable = 1'b0; end
      else if ($urandom_range(0, 79) == 0) begin en_hold = $urandom_range(1, 3); enable = 1'b0; end
      else enable = 1'b1;
      pct = ((c / 100) % 3 == 0) ? 20 : (((c / 100) % 3 == 1) ? 50 : 90);
      v0 = ($urandom_range(0, 99) < pct);
      v1 = ($urandom_range(0, 99) < pct);
      drive(v0, rnd(), v1, rnd());
      #1; model_comb();
      if (v0) begin
        n_cmp++; if (src0_ready !== er0) begin n_err++; $display("FAIL rnd_ready0[%0d]: got %b want %b", c, src0_ready, er0); end
      end
      if (v1) begin
        n_cmp++; if (src1_ready !== er1) begin n_err++; $display("FAIL rnd_ready1[%0d]: got %b want %b", c, src1_ready, er1); end
      end
      clk_cycle();
      el = LW'(q.size());
      n_cmp++; if (data !== m_data) begin n_err++; $display("FAIL rnd_data[%0d]: got %h want %h", c, data, m_data); end
      n_cmp++; if (level !== el) begin n_err++; $display("FAIL rnd_level[%0d]: got %0d want %0d", c, level, el); end
      n_cmp++; if (underrun !== m_under) begin n_err++; $display("FAIL rnd_underrun[%0d]: got %b want %b", c, underrun, m_under); end
      n_cmp++; if (busy !== (phase != 0)) begin n_err++; $display("FAIL rnd_busy[%0d]: got %b want %b", c, busy, phase != 0); end
`ifdef AUDIO_SCHED_UNDERRUN_CNT_EN
      n_cmp++; if (underrun_cnt !== 16'(m_ucnt)) begin n_err++; $display("FAIL rnd_ucnt[%0d]: got %0d want %0d", c, underrun_cnt, m_ucnt); end
`endif
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_prime_serve();
    test_alternate();
    test_underrun();
    test_simultaneous();
    test_enable_off();
    test_reset_midframe();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
